// File: rtl/kraken_mem_pkg.sv
// ============================================================================
// Package  : kraken_mem_pkg
// Brief    : Shared defaults, FSM encoding and helpers for the mem_resp slice.
// Revision : 1.0
// ============================================================================
`default_nettype none

package kraken_mem_pkg;

    localparam int c_MEM_WORDS  = 4096;
    localparam int c_LINE_WORDS = 4;
    localparam int c_RD_LAT     = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAT    = 3'd1,
        RBURST = 3'd2,
        WDATA  = 3'd3,
        ACK    = 3'd4
    } state_t;

    // Counter widths must stay at least one bit even for a depth of one.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_resp_ram.sv
// ============================================================================
// Module   : mem_resp_ram
// Brief    : Single-port synchronous RAM, one-cycle read latency, held output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_resp_ram #(
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic          i_re,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // Read data only updates on a read strobe so a stalled beat stays put.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/mem_resp.sv
// ============================================================================
// Module   : mem_resp
// Brief    : Line-burst memory responder (fill bursts, writeback + ack).
//            Define MEM_RESP_SEGCHK_EN to flag out-of-range line addresses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_resp
    import kraken_mem_pkg::*;
#(
    parameter int MEM_WORDS  = c_MEM_WORDS,
    parameter int LINE_WORDS = c_LINE_WORDS,
    parameter int RD_LAT     = c_RD_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic        wdat_valid,
    output logic        wdat_ready,
    input  logic [31:0] wdat,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_last,
    output logic        resp_err
);

    localparam int c_AW = clog2_min1(MEM_WORDS);
    localparam int c_BW = clog2_min1(LINE_WORDS);
    localparam int c_LW = clog2_min1(RD_LAT);

    localparam logic [c_AW-1:0] c_LINE_MASK = ~c_AW'(LINE_WORDS - 1);
    localparam logic [c_BW-1:0] c_LAST_BEAT = c_BW'(LINE_WORDS - 1);
    localparam logic [c_LW-1:0] c_LAT_END   = c_LW'(RD_LAT - 1);

    state_t          r_state, w_state_nxt;
    logic [c_AW-1:0] r_line,  w_line_nxt;
    logic [c_BW-1:0] r_beat,  w_beat_nxt;
    logic [c_LW-1:0] r_lat,   w_lat_nxt;
    logic            r_err,   w_err_nxt;

    logic            w_req_fire;
    logic            w_wdat_fire;
    logic            w_resp_fire;
    logic            w_oob;
    logic            w_last_beat;
    logic [c_AW-1:0] w_req_line;

    logic            w_ram_we;
    logic            w_ram_re;
    logic [c_AW-1:0] w_ram_addr;
    logic [31:0]     w_ram_rdata;
    logic            w_unused_addr;

    assign req_ready   = (r_state == IDLE) && rst_n;
    assign wdat_ready  = (r_state == WDATA);
    assign resp_valid  = (r_state == RBURST) || (r_state == ACK);
    assign w_last_beat = (r_beat == c_LAST_BEAT);
    assign resp_last   = (r_state == ACK) || ((r_state == RBURST) && w_last_beat);
    assign resp_data   = (r_state == RBURST) ? w_ram_rdata : 32'h0;

    assign w_req_fire  = req_valid && req_ready;
    assign w_wdat_fire = wdat_valid && wdat_ready;
    assign w_resp_fire = resp_valid && resp_ready;

    // Line base word index; offset bits within the line are dropped.
    assign w_req_line    = req_addr[c_AW+1:2] & c_LINE_MASK;
    assign w_unused_addr = ^req_addr;

`ifdef MEM_RESP_SEGCHK_EN
    // Compared on the full word address so lines near 2^32 never alias to 0.
    assign w_oob    = ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
    assign resp_err = (r_state == ACK) && r_err;
`else
    assign w_oob    = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_line  <= '0;
            r_beat  <= '0;
            r_lat   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_line  <= w_line_nxt;
            r_beat  <= w_beat_nxt;
            r_lat   <= w_lat_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_line_nxt  = r_line;
        w_beat_nxt  = r_beat;
        w_lat_nxt   = r_lat;
        w_err_nxt   = r_err;
        w_ram_we    = 1'b0;
        w_ram_re    = 1'b0;
        w_ram_addr  = r_line | c_AW'(r_beat);

        case (r_state)
            IDLE: begin
                if (w_req_fire) begin
                    w_line_nxt  = w_req_line;
                    w_beat_nxt  = '0;
                    w_lat_nxt   = '0;
                    w_err_nxt   = w_oob;
                    w_state_nxt = req_wr ? WDATA : LAT;
                end
            end
            LAT: begin
                // Word 0 is fetched in the last latency cycle so it lands with RBURST.
                if (r_lat == c_LAT_END) begin
                    w_ram_re    = !r_err;
                    w_ram_addr  = r_line;
                    w_state_nxt = r_err ? ACK : RBURST;
                end else begin
                    w_lat_nxt = r_lat + c_LW'(1);
                end
            end
            RBURST: begin
                if (w_resp_fire) begin
                    if (w_last_beat) begin
                        w_beat_nxt  = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_beat_nxt = r_beat + c_BW'(1);
                        w_ram_re   = 1'b1;
                        w_ram_addr = r_line | c_AW'(r_beat + c_BW'(1));
                    end
                end
            end
            WDATA: begin
                if (w_wdat_fire) begin
                    w_ram_we = !r_err;
                    if (w_last_beat) begin
                        w_beat_nxt  = '0;
                        w_state_nxt = ACK;
                    end else begin
                        w_beat_nxt = r_beat + c_BW'(1);
                    end
                end
            end
            ACK: begin
                if (w_resp_fire) begin
                    w_err_nxt   = 1'b0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    mem_resp_ram #(
        .DEPTH (MEM_WORDS),
        .AW    (c_AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (wdat),
        .o_rdata (w_ram_rdata)
    );

endmodule

`default_nettype wire

// File: tb/tb_mem_resp.sv
// ============================================================================
// Module   : tb_mem_resp
// Brief    : Directed self-checking bench for mem_resp (default parameters).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mem_resp;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic [31:0] req_addr;
    logic        wdat_valid;
    logic        wdat_ready;
    logic [31:0] wdat;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_last;
    logic        resp_err;

    int errors = 0;
    int checks = 0;

    logic [31:0] rd_data [8];
    logic        rd_last [8];
    int          rd_n;
    int          rd_lat;
    logic        rd_err;
    logic        ack_valid, ack_last, ack_err;
    logic [31:0] ack_data;

    mem_resp #(
        .MEM_WORDS  (4096),
        .LINE_WORDS (4),
        .RD_LAT     (4)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wr     (req_wr),
        .req_addr   (req_addr),
        .wdat_valid (wdat_valid),
        .wdat_ready (wdat_ready),
        .wdat       (wdat),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_last  (resp_last),
        .resp_err   (resp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_req_accept();
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL req_accept_timeout: req_ready=%0b required 1", req_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3);
        logic [31:0] d [4];
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        req_addr = addr; req_wr = 1'b1; req_valid = 1'b1;
        wait_req_accept();
        req_valid = 1'b0; req_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            int n = 0;
            wdat = d[i]; wdat_valid = 1'b1;
            while (!wdat_ready && n < 20) begin
                @(posedge clk); #1; n++;
            end
            checks++;
            if (!wdat_ready) begin
                errors++;
                $display("FAIL wdat_timeout: wdat_ready=%0b required 1 (beat %0d)", wdat_ready, i);
            end
            @(posedge clk); #1;
        end
        wdat_valid = 1'b0;
        ack_valid = resp_valid; ack_last = resp_last; ack_err = resp_err; ack_data = resp_data;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr);
        logic last;
        rd_n = 0; rd_lat = 0; rd_err = 1'b0;
        resp_ready = 1'b1;
        req_addr = addr; req_wr = 1'b0; req_valid = 1'b1;
        wait_req_accept();
        req_valid = 1'b0;
        while (!resp_valid && rd_lat < 50) begin
            @(posedge clk); #1; rd_lat++;
        end
        while (resp_valid && rd_n < 8) begin
            rd_data[rd_n] = resp_data;
            rd_last[rd_n] = resp_last;
            rd_err = rd_err | resp_err;
            last = resp_last;
            rd_n++;
            @(posedge clk); #1;
            if (last) break;
        end
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 32'h0;
        wdat_valid = 1'b0; wdat = 32'h0; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %0b required 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %0b required 0", resp_valid); end
        checks++; if (wdat_ready !== 1'b0) begin errors++; $display("FAIL reset_wdat_ready: got %0b required 0", wdat_ready); end
        checks++; if ({resp_last, resp_err} !== 2'b00) begin errors++; $display("FAIL reset_last_err: got %b required 00", {resp_last, resp_err}); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("FAIL reset_resp_data: got %h required 0", resp_data); end
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wdat_valid = 1'b1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready: got %0b required 1", req_ready); end
        #1;
        checks++; if (wdat_ready !== 1'b0) begin errors++; $display("FAIL idle_wdat_ignored: wdat_ready=%0b required 0", wdat_ready); end
        @(posedge clk); #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL idle_no_resp: resp_valid=%0b required 0", resp_valid); end
        wdat_valid = 1'b0;
    endtask

    task automatic test_read();
        do_write(32'h0000_0100, 32'd1, 32'd2, 32'd3, 32'd4);
        checks++;
        if ({ack_valid, ack_last, ack_err, ack_data} !== {3'b110, 32'h0}) begin
            errors++; $display("FAIL read_preload_ack: got v%0b l%0b e%0b d%h required v1 l1 e0 d0", ack_valid, ack_last, ack_err, ack_data);
        end
        do_read(32'h0000_0100);
        checks++; if (rd_lat !== 4) begin errors++; $display("FAIL read_latency: got %0d required 4", rd_lat); end
        checks++; if (rd_n !== 4) begin errors++; $display("FAIL read_beats: got %0d required 4", rd_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== 32'(i + 1) || rd_last[i] !== (i == 3)) begin
                errors++; $display("FAIL read_beat%0d: got d%h l%0b required d%h l%0b", i, rd_data[i], rd_last[i], i + 1, i == 3);
            end
        end
        checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL read_err: got %0b required 0", rd_err); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL read_return_idle: req_ready=%0b required 1", req_ready); end
    endtask

    task automatic test_write_read();
        logic [31:0] exp [4];
        exp[0] = 32'h0000_00A0; exp[1] = 32'h0000_00A1; exp[2] = 32'h0000_00A2; exp[3] = 32'h0000_00A3;
        do_write(32'h0000_0200, exp[0], exp[1], exp[2], exp[3]);
        checks++;
        if ({ack_valid, ack_last, ack_err, ack_data} !== {3'b110, 32'h0}) begin
            errors++; $display("FAIL wr_ack: got v%0b l%0b e%0b d%h required v1 l1 e0 d0", ack_valid, ack_last, ack_err, ack_data);
        end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL wr_single_ack: resp_valid=%0b required 0", resp_valid); end
        do_read(32'h0000_0208);
        checks++; if (rd_n !== 4) begin errors++; $display("FAIL wr_rd_beats: got %0d required 4", rd_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== exp[i]) begin errors++; $display("FAIL wr_rd_beat%0d: got %h required %h", i, rd_data[i], exp[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp [4];
        int n = 0;
        exp[0] = 32'h0000_00A0; exp[1] = 32'h0000_00A1; exp[2] = 32'h0000_00A2; exp[3] = 32'h0000_00A3;
        resp_ready = 1'b1;
        req_addr = 32'h0000_0200; req_wr = 1'b0; req_valid = 1'b1;
        wait_req_accept();
        req_valid = 1'b0;
        while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                resp_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    checks++;
                    if (resp_valid !== 1'b1 || resp_data !== exp[2] || resp_last !== 1'b0) begin
                        errors++; $display("FAIL bp_hold%0d: got v%0b d%h l%0b required v1 d%h l0", s, resp_valid, resp_data, resp_last, exp[2]);
                    end
                    @(posedge clk); #1;
                end
                resp_ready = 1'b1;
            end
            checks++;
            if (resp_valid !== 1'b1 || resp_data !== exp[b] || resp_last !== (b == 3)) begin
                errors++; $display("FAIL bp_beat%0d: got v%0b d%h l%0b required v1 d%h l%0b", b, resp_valid, resp_data, resp_last, exp[b], b == 3);
            end
            @(posedge clk); #1;
        end
        resp_ready = 1'b0;
        checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_no_extra: resp_valid=%0b req_ready=%0b required 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic test_back_to_back();
        do_write(32'h0000_0300, 32'hDEAD_0000, 32'hDEAD_0001, 32'hDEAD_0002, 32'hDEAD_0003);
        do_read(32'h0000_030C);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== (32'hDEAD_0000 + 32'(i))) begin errors++; $display("FAIL b2b_new_line%0d: got %h required %h", i, rd_data[i], 32'hDEAD_0000 + 32'(i)); end
        end
        do_read(32'h0000_0204);
        checks++; if (rd_data[3] !== 32'h0000_00A3) begin errors++; $display("FAIL b2b_old_line: got %h required 000000a3", rd_data[3]); end
    endtask

`ifdef MEM_RESP_SEGCHK_EN
    task automatic test_segfault();
        do_read(32'h0001_0000);
        checks++; if (rd_lat !== 4) begin errors++; $display("FAIL seg_latency: got %0d required 4", rd_lat); end
        checks++; if (rd_n !== 1) begin errors++; $display("FAIL seg_beats: got %0d required 1", rd_n); end
        checks++;
        if (rd_err !== 1'b1 || rd_last[0] !== 1'b1 || rd_data[0] !== 32'h0) begin
            errors++; $display("FAIL seg_beat: got e%0b l%0b d%h required e1 l1 d0", rd_err, rd_last[0], rd_data[0]);
        end
        do_write(32'h0001_0100, 32'h5, 32'h6, 32'h7, 32'h8);
        checks++;
        if ({ack_valid, ack_last, ack_err, ack_data} !== {3'b111, 32'h0}) begin
            errors++; $display("FAIL seg_wr_ack: got v%0b l%0b e%0b d%h required v1 l1 e1 d0", ack_valid, ack_last, ack_err, ack_data);
        end
        do_read(32'h0000_0100);
        checks++; if (rd_data[0] !== 32'd1) begin errors++; $display("FAIL seg_wr_discard: got %h required 1", rd_data[0]); end
    endtask
`else
    task automatic test_alias();
        do_read(32'h0001_0100);
        checks++; if (rd_n !== 4) begin errors++; $display("FAIL alias_beats: got %0d required 4", rd_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== 32'(i + 1)) begin errors++; $display("FAIL alias_beat%0d: got %h required %h", i, rd_data[i], i + 1); end
        end
        checks++; if (rd_err !== 1'b0) begin errors++; $display("FAIL alias_err: got %0b required 0", rd_err); end
    endtask
`endif

    task automatic test_reset_mid_read();
        int n = 0;
        resp_ready = 1'b1;
        req_addr = 32'h0000_0100; req_wr = 1'b0; req_valid = 1'b1;
        wait_req_accept();
        req_valid = 1'b0;
        while (!resp_valid && n < 50) begin @(posedge clk); #1; n++; end
        checks++; if (resp_data !== 32'd1) begin errors++; $display("FAIL mid_first_beat: got %h required 1", resp_data); end
        @(posedge clk); #1;
        rst_n = 1'b0;
        resp_ready = 1'b0;
        #1;
        checks++;
        if ({req_ready, wdat_ready, resp_valid, resp_last, resp_err} !== 5'b0 || resp_data !== 32'h0) begin
            errors++; $display("FAIL mid_reset_outputs: got rr%0b wr%0b v%0b l%0b e%0b d%h required all 0",
                               req_ready, wdat_ready, resp_valid, resp_last, resp_err, resp_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL mid_release: req_ready=%0b resp_valid=%0b required 1 0", req_ready, resp_valid);
        end
        do_read(32'h0000_0100);
        checks++; if (rd_n !== 4) begin errors++; $display("FAIL mid_reread_beats: got %0d required 4", rd_n); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd_data[i] !== 32'(i + 1)) begin errors++; $display("FAIL mid_reread_beat%0d: got %h required %h", i, rd_data[i], i + 1); end
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_read();
        test_backpressure();
        test_back_to_back();
`ifdef MEM_RESP_SEGCHK_EN
        test_segfault();
`else
        test_alias();
`endif
        test_reset_mid_read();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 4096, meaning backing-store depth in 32-bit words (power of two).
REQ-002 SHALL have parameter LINE_WORDS, default 4, meaning words per cache line and burst length.
REQ-003 SHALL have parameter RD_LAT, default 4, meaning cycles from read-request accept to first data beat (>=1).
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-006 SHALL have port req_valid  in  1  cache controller presents a line request.
REQ-007 SHALL have port req_ready  out  1  responder accepts a request this cycle.
REQ-008 SHALL have port req_wr  in  1  1 = line writeback, 0 = line fill.
REQ-009 SHALL have port req_addr  in  32  byte address of line; bits [log2(LINE_WORDS*4)-1:0] ignored.
REQ-010 SHALL have port wdat_valid  in  1  writeback data beat valid.
REQ-011 SHALL have port wdat_ready  out  1  writeback data beat accepted.
REQ-012 SHALL have port wdat  in  32  writeback data word.
REQ-013 SHALL have port resp_valid  out  1  response beat valid.
REQ-014 SHALL have port resp_ready  in  1  cache controller accepts response beat.
REQ-015 SHALL have port resp_data  out  32  fill word or 0 on write ack/error.
REQ-016 SHALL have port resp_last  out  1  final beat of response.
REQ-017 SHALL have port resp_err  out  1  segfault: address outside backing store.

Function
REQ-018 SHALL implement FSM states IDLE, LAT, RBURST, WDATA, ACK.
REQ-019 SHALL assert req_ready only in IDLE; a request is accepted when req_valid && req_ready.
REQ-020 SHALL on accepted read go IDLE->LAT, count RD_LAT-1 cycles, then RBURST so first resp_valid rises exactly RD_LAT cycles after accept.
REQ-021 SHALL in RBURST emit LINE_WORDS beats, words 0..LINE_WORDS-1 in ascending address order, resp_last on final beat only.
REQ-022 SHALL hold resp_data/resp_last/resp_err stable while resp_valid && !resp_ready; a beat completes on resp_valid && resp_ready.
REQ-023 SHALL on accepted write go IDLE->WDATA, assert wdat_ready, write each accepted beat to ascending word address, wrap word index modulo LINE_WORDS.
REQ-024 SHALL after the LINE_WORDS-th accepted wdat beat enter ACK and present one beat resp_valid=1, resp_last=1, resp_data=0 the next cycle.
REQ-025 SHALL return to IDLE after the last response beat handshakes; req_ready may rise the following cycle.
REQ-026 SHALL ignore wdat_valid outside WDATA and ignore req_valid outside IDLE.
REQ-027 SHALL treat line address wrap at the top of the 32-bit space as out of range, never as wrap to 0.

Reset
REQ-028 SHALL on rst_n low force state IDLE, counters 0, req_ready 0 during reset then 1 the first cycle after release, wdat_ready/resp_valid/resp_last/resp_err 0, resp_data 0.
REQ-029 SHALL abandon any in-flight burst on reset; partially written lines keep already-written words; memory contents are not cleared.

Configuration
REQ-030 SHALL with MEM_RESP_SEGCHK_EN defined flag addresses >= MEM_WORDS*4: read returns one beat resp_err=1, resp_last=1, resp_data=0 after RD_LAT; write consumes and discards LINE_WORDS beats then acks with resp_err=1.
REQ-031 SHALL without MEM_RESP_SEGCHK_EN tie resp_err to 0 and index memory with the low address bits (aliasing).

Structure
REQ-032 SHALL place the state enum, MEM_WORDS/LINE_WORDS/RD_LAT defaults in package kraken_mem_pkg.
REQ-033 SHALL instantiate one sub-module mem_resp_ram: single-port synchronous RAM, one-cycle read latency, absorbed inside LAT/RBURST timing.

Verification
REQ-034 SHALL test read: preload words 0x100..0x10C = 1,2,3,4; read 0x100 at cycle 10 -> beats 1,2,3,4 at cycles 14-17, resp_last at 17.
REQ-035 SHALL test write-then-read: write 0x200 with A0,A1,A2,A3 -> single ack beat; read 0x208 -> beats A0..A3 (low bits ignored).
REQ-036 SHALL test backpressure: resp_ready low for 3 cycles on beat 2 -> data held, no beat lost or duplicated.
REQ-037 SHALL test segfault (macro on): read 0x0001_0000 with MEM_WORDS=4096 -> one beat resp_err=1, resp_last=1, data 0.
REQ-038 SHALL test reset mid-read after beat 1 -> all outputs 0, req_ready 1 after release, next read returns correct data.
